// File: rtl/ufir_ref_comparator_if.sv
// Sample bus between the UFIR bench and the reference comparator: reference stage
// outputs, the shared clock enable, and the RTL filter output with its valid strobe.
interface ufir_ref_comparator_if;
  logic               clk_enable;
  logic signed [15:0] ref_1;
  logic signed [15:0] ref_2;
  logic               dut_valid;
  logic signed [15:0] dut_1;
  logic signed [15:0] dut_2;

  modport master (
    output clk_enable, ref_1, ref_2, dut_valid, dut_1, dut_2
  );

  modport slave (
    input clk_enable, ref_1, ref_2, dut_valid, dut_1, dut_2
  );
endinterface

// File: rtl/ufir_ref_comparator.sv
// Aligns reference-model samples with RTL filter outputs through a FIFO and compares
// both int16 channels against an absolute tolerance, keeping error statistics.
module ufir_ref_comparator #(
  parameter int unsigned OVERCLK = 5,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TOL     = 0,
  parameter int unsigned SKIP    = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ufir_ref_comparator_if.slave  smp,
  output logic                  mismatch,
  output logic [CNT_W-1:0]      err_cnt_1,
  output logic [CNT_W-1:0]      err_cnt_2,
  output logic [CNT_W-1:0]      pair_cnt,
  output logic [CNT_W-1:0]      first_err,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  done_ok
);

  localparam int unsigned      PH_W    = $clog2(OVERCLK + 1);
  localparam int unsigned      AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] SKIP_V  = CNT_W'(SKIP);
  localparam logic [16:0]      TOL_V   = 17'(TOL);

  typedef enum logic [1:0] {WARMUP, CHECK, FAULT} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // |a - b| over the full int16 range needs 17 bits (up to 65535).
  function automatic logic [16:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    return d[16] ? (~d + 17'd1) : d;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference cadence: the reference stage updates on the first enabled cycle of
  // each OVERCLK group; its outputs are stable one cycle later, when we capture.
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0] phase;
  logic            upd;
  logic            upd_d;

  assign upd = smp.clk_enable & (phase == PH_W'(1));

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= PH_W'(1);
      upd_d <= 1'b0;
    end else begin
      upd_d <= upd;
      if (smp.clk_enable) begin
        phase <= (phase == PH_W'(OVERCLK)) ? PH_W'(1) : phase + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        do_push;
  logic        do_pop;
  logic        ovf_set;
  logic        unf_set;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = smp.dut_valid & ~empty;
  assign do_push = upd_d & (~full | do_pop);
  assign ovf_set = upd_d & full & ~do_pop;
  assign unf_set = smp.dut_valid & empty;

  // NOTE: the storage array is deliberately not reset; only the pointers say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= {smp.ref_1, smp.ref_2};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare datapath: evaluated in the pop cycle, results registered below
  // ---------------------------------------------------------------------------
  logic [15:0] head_1;
  logic [15:0] head_2;
  logic        fail_1;
  logic        fail_2;

  assign {head_1, head_2} = mem[rd_ptr[AW-1:0]];
  assign fail_1 = abs_diff(head_1, smp.dut_1) > TOL_V;
  assign fail_2 = abs_diff(head_2, smp.dut_2) > TOL_V;

  // ---------------------------------------------------------------------------
  // Check FSM with saturating statistics
  // ---------------------------------------------------------------------------
  state_t state;
  logic   err_seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WARMUP;
      mismatch  <= 1'b0;
      err_cnt_1 <= '0;
      err_cnt_2 <= '0;
      pair_cnt  <= '0;
      first_err <= '1;
      err_seen  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;

      unique case (state)
        WARMUP: begin
          if (do_pop) pair_cnt <= sat_inc(pair_cnt);
          if (ovf_set || unf_set) begin
            state <= FAULT;
          end else if ((SKIP == 0) || (do_pop && (sat_inc(pair_cnt) == SKIP_V))) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (ovf_set || unf_set) state <= FAULT;
          if (do_pop) begin
            pair_cnt <= sat_inc(pair_cnt);
            mismatch <= fail_1 | fail_2;
            if (fail_1) err_cnt_1 <= sat_inc(err_cnt_1);
            if (fail_2) err_cnt_2 <= sat_inc(err_cnt_2);
            if ((fail_1 || fail_2) && !err_seen) begin
              first_err <= pair_cnt;
              err_seen  <= 1'b1;
            end
          end
        end
        FAULT: begin
          // Pops still drain the FIFO; statistics stay frozen until reset.
        end
        default: state <= FAULT;
      endcase
    end
  end

  assign done_ok = (state == CHECK) && (err_cnt_1 == '0) && (err_cnt_2 == '0);

endmodule

// File: tb/tb_ufir_ref_comparator.sv
// Directed bench for ufir_ref_comparator: three instances (TOL 0, 1, 32767) share one
// stimulus bus and are checked every cycle against a queue-based model plus literals.
module tb_ufir_ref_comparator;

  localparam int OVERCLK = 5;
  localparam int DEPTH   = 16;
  localparam int SKIP    = 4;
  localparam int CNT_W   = 32;
  localparam int NI      = 3;
  localparam logic [CNT_W-1:0] ONES = '1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ufir_ref_comparator_if bus ();

  logic             mis [NI];
  logic [CNT_W-1:0] e1  [NI];
  logic [CNT_W-1:0] e2  [NI];
  logic [CNT_W-1:0] pc  [NI];
  logic [CNT_W-1:0] fe  [NI];
  logic             ovf [NI];
  logic             unf [NI];
  logic             dok [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ufir_ref_comparator #(
      .OVERCLK(OVERCLK),
      .DEPTH  (DEPTH),
      .TOL    (g == 0 ? 0 : (g == 1 ? 1 : 32767)),
      .SKIP   (SKIP),
      .CNT_W  (CNT_W)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .smp      (bus.slave),
      .mismatch (mis[g]),
      .err_cnt_1(e1[g]),
      .err_cnt_2(e2[g]),
      .pair_cnt (pc[g]),
      .first_err(fe[g]),
      .overflow (ovf[g]),
      .underflow(unf[g]),
      .done_ok  (dok[g])
    );
  end

  function automatic int tol_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 32767);
  endfunction

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] @%0t: got %0d, expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue of captured reference pairs and plain counters
  // ---------------------------------------------------------------------------
  int               q1[$];
  int               q2[$];
  int               m_en_cnt;
  bit               m_upd_d;
  bit               m_fault, m_ovf, m_unf;
  logic [CNT_W-1:0] m_pc [NI];
  logic [CNT_W-1:0] m_e1 [NI];
  logic [CNT_W-1:0] m_e2 [NI];
  logic [CNT_W-1:0] m_fe [NI];
  bit               m_seen [NI];
  bit               m_mis  [NI];
  int               mis_cnt [NI];

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == ONES) ? v : v + 1;
  endfunction

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_en_cnt = 0;
    m_upd_d  = 1'b0;
    m_fault  = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_pc[i] = '0; m_e1[i] = '0; m_e2[i] = '0; m_fe[i] = ONES;
      m_seen[i] = 1'b0; m_mis[i] = 1'b0;
    end
  endtask

  task automatic score(input int i, input int d1, input int d2);
    bit f1, f2;
    if (m_fault) return;
    if (m_pc[i] < SKIP) begin
      m_pc[i] = inc_sat(m_pc[i]);
      return;
    end
    f1 = ((d1 < 0) ? -d1 : d1) > tol_of(i);
    f2 = ((d2 < 0) ? -d2 : d2) > tol_of(i);
    if ((f1 || f2) && !m_seen[i]) begin
      m_fe[i]   = m_pc[i];
      m_seen[i] = 1'b1;
    end
    m_pc[i]  = inc_sat(m_pc[i]);
    if (f1) m_e1[i] = inc_sat(m_e1[i]);
    if (f2) m_e2[i] = inc_sat(m_e2[i]);
    m_mis[i] = f1 || f2;
  endtask

  task automatic model_step(input bit ce, input int r1, input int r2,
                            input bit dv, input int d1, input int d2);
    bit push;
    int h1, h2;
    push    = m_upd_d;
    m_upd_d = ce && (m_en_cnt % OVERCLK == 0);
    if (ce) m_en_cnt++;
    for (int i = 0; i < NI; i++) m_mis[i] = 1'b0;
    if (dv) begin
      if (q1.size() == 0) begin
        m_unf = 1'b1;
        m_fault = 1'b1;
      end else begin
        h1 = q1.pop_front();
        h2 = q2.pop_front();
        for (int i = 0; i < NI; i++) score(i, h1 - d1, h2 - d2);
      end
    end
    if (push) begin
      if (q1.size() < DEPTH) begin
        q1.push_back(r1);
        q2.push_back(r2);
      end else begin
        m_ovf = 1'b1;
        m_fault = 1'b1;
      end
    end
  endtask

  // Model advances on the inputs seen at the edge; DUT outputs compared 1 ns later.
  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_step(bus.clk_enable, int'(bus.ref_1), int'(bus.ref_2),
                    bus.dut_valid, int'(bus.dut_1), int'(bus.dut_2));
    #1;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("mismatch",  i, 64'(mis[i]), 64'(m_mis[i]));
        check("err_cnt_1", i, 64'(e1[i]),  64'(m_e1[i]));
        check("err_cnt_2", i, 64'(e2[i]),  64'(m_e2[i]));
        check("pair_cnt",  i, 64'(pc[i]),  64'(m_pc[i]));
        check("first_err", i, 64'(fe[i]),  64'(m_fe[i]));
        check("overflow",  i, 64'(ovf[i]), 64'(m_ovf));
        check("underflow", i, 64'(unf[i]), 64'(m_unf));
        check("done_ok",   i, 64'(dok[i]),
              64'(!m_fault && m_pc[i] >= SKIP && m_e1[i] == 0 && m_e2[i] == 0));
        if (mis[i] === 1'b1) mis_cnt[i]++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: reference-stage emulation driven from tables
  // ---------------------------------------------------------------------------
  int rtab1 [64];
  int rtab2 [64];
  int dtab1 [64];
  int dtab2 [64];
  int drv_en;
  int upd_cnt;

  task automatic set_ramp();
    for (int j = 0; j < 64; j++) begin
      rtab1[j] = j + 1;
      rtab2[j] = 1000 + j;
      dtab1[j] = rtab1[j];
      dtab2[j] = rtab2[j];
    end
  endtask

  // One clock: inputs applied at the falling edge; the reference updates after its upd edge.
  task automatic tick(input bit ce, input bit dv, input int d1, input int d2);
    bit upd_edge;
    bus.clk_enable = ce;
    bus.dut_valid  = dv;
    bus.dut_1      = 16'(d1);
    bus.dut_2      = 16'(d2);
    @(posedge clk);
    upd_edge = ce && (drv_en % OVERCLK == 0);
    if (ce) drv_en++;
    @(negedge clk);
    bus.dut_valid = 1'b0;
    if (upd_edge) begin
      bus.ref_1 = 16'(rtab1[upd_cnt % 64]);
      bus.ref_2 = 16'(rtab2[upd_cnt % 64]);
      upd_cnt++;
    end
  endtask

  // n pairs, each output sample issued 3 reference samples after its reference.
  task automatic run_pairs(input int n, input int gap_at);
    int  sent;
    bit  gapped;
    sent   = 0;
    gapped = 1'b0;
    for (int p = 0; p < 200 && sent < n; p++) begin
      if (sent == gap_at && !gapped) begin
        repeat (7) tick(1'b0, 1'b0, 0, 0);
        gapped = 1'b1;
      end
      for (int t = 0; t < OVERCLK; t++) begin
        if (t == 2 && sent < n && upd_cnt > sent + 3) begin
          tick(1'b1, 1'b1, dtab1[sent], dtab2[sent]);
          sent++;
        end else begin
          tick(1'b1, 1'b0, 0, 0);
        end
      end
    end
    check("pairs_sent", 0, 64'(sent), 64'(n));
    repeat (2) tick(1'b0, 1'b0, 0, 0);
  endtask

  task automatic expect_out(input int i, input int e_pc, input int e_e1, input int e_e2,
                            input logic [CNT_W-1:0] e_fe, input bit e_ovf, input bit e_unf,
                            input bit e_dok, input int e_mis);
    check("lit_pair_cnt",  i, 64'(pc[i]),  64'(e_pc));
    check("lit_err_cnt_1", i, 64'(e1[i]),  64'(e_e1));
    check("lit_err_cnt_2", i, 64'(e2[i]),  64'(e_e2));
    check("lit_first_err", i, 64'(fe[i]),  64'(e_fe));
    check("lit_overflow",  i, 64'(ovf[i]), 64'(e_ovf));
    check("lit_underflow", i, 64'(unf[i]), 64'(e_unf));
    check("lit_done_ok",   i, 64'(dok[i]), 64'(e_dok));
    check("lit_pulses",    i, 64'(mis_cnt[i]), 64'(e_mis));
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.clk_enable = 1'b0;
    bus.dut_valid  = 1'b0;
    bus.ref_1      = '0;
    bus.ref_2      = '0;
    drv_en         = 0;
    upd_cnt        = 0;
    #1;
    for (int i = 0; i < NI; i++) begin
      mis_cnt[i] = 0;
      check("rst_mismatch", i, 64'(mis[i]), 64'(0));
      expect_out(i, 0, 0, 0, ONES, 1'b0, 1'b0, 1'b0, 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.clk_enable = 1'b0;
    bus.dut_valid  = 1'b0;
    bus.ref_1 = '0; bus.ref_2 = '0; bus.dut_1 = '0; bus.dut_2 = '0;
    for (int i = 0; i < NI; i++) mis_cnt[i] = 0;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: clean ramp, 40 pairs
    do_reset();
    set_ramp();
    run_pairs(40, -1);
    for (int i = 0; i < NI; i++) expect_out(i, 40, 0, 0, ONES, 1'b0, 1'b0, 1'b1, 0);

    // 2: pair 10 channel 1 off by +1 (fails only at TOL=0)
    do_reset();
    set_ramp();
    dtab1[10] = rtab1[10] + 1;
    run_pairs(40, -1);
    expect_out(0, 40, 1, 0, 32'd10, 1'b0, 1'b0, 1'b0, 1);
    expect_out(1, 40, 0, 0, ONES,   1'b0, 1'b0, 1'b1, 0);
    expect_out(2, 40, 0, 0, ONES,   1'b0, 1'b0, 1'b1, 0);

    // 3: int16 extremes; pair 1 differs but is inside warm-up
    do_reset();
    set_ramp();
    dtab1[1] = rtab1[1] + 5;
    rtab1[4] = 0;      dtab1[4] = 0;      rtab2[4] = -32768; dtab2[4] = 32767;
    rtab1[5] = -32768; dtab1[5] = -32768; rtab2[5] = -32768; dtab2[5] = -32768;
    rtab1[6] = 32767;  dtab1[6] = -32768; rtab2[6] = 7;      dtab2[6] = 7;
    rtab1[7] = 100;    dtab1[7] = 99;     rtab2[7] = 0;      dtab2[7] = 0;
    run_pairs(8, -1);
    expect_out(0, 8, 2, 1, 32'd4, 1'b0, 1'b0, 1'b0, 3);
    expect_out(1, 8, 1, 1, 32'd4, 1'b0, 1'b0, 1'b0, 2);
    expect_out(2, 8, 1, 1, 32'd4, 1'b0, 1'b0, 1'b0, 2);

    // 4: output stalls long enough to overflow, then late wrong pops are not counted
    do_reset();
    set_ramp();
    run_pairs(6, -1);
    repeat ((DEPTH + 2) * OVERCLK) tick(1'b1, 1'b0, 0, 0);
    repeat (5) tick(1'b0, 1'b1, 999, -999);
    repeat (2) tick(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < NI; i++) expect_out(i, 6, 0, 0, ONES, 1'b1, 1'b0, 1'b0, 0);

    // 5: output before any reference sample
    do_reset();
    set_ramp();
    tick(1'b0, 1'b1, 0, 0);
    run_pairs(6, -1);
    for (int i = 0; i < NI; i++) expect_out(i, 0, 0, 0, ONES, 1'b0, 1'b1, 1'b0, 0);

    // 6: reset with 5 queued samples, then test 1 again with a 7-cycle enable gap
    do_reset();
    set_ramp();
    repeat (5 * OVERCLK) tick(1'b1, 1'b0, 0, 0);
    do_reset();
    set_ramp();
    run_pairs(40, 20);
    for (int i = 0; i < NI; i++) expect_out(i, 40, 0, 0, ONES, 1'b0, 1'b0, 1'b1, 0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
